// File: rtl/sobel_engine_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_engine_param_if
// Description : Control, picture-read and edge-write signals of the Sobel
//               engine, gathered into one bundle.
//               master : the engine (drives addresses, write strobe, status)
//               slave  : the surroundings (controller and the two BRAMs)
//   start       controller -> engine   one-cycle frame start pulse
//   mode        controller -> engine   0: Gx^2+Gy^2, 1: |Gx|+|Gy|
//   threshold   controller -> engine   magnitude threshold
//   busy, done  engine -> controller   frame status
//   pixel_data  picture BRAM -> engine read data {R,G,B}
//   pic_addr    engine -> picture BRAM read address
//   edge_we, edge_addr, edge_data      engine -> edge BRAM write port
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_engine_param_if #(
    parameter int CH_W   = 4,
    parameter int EDGE_W = 3,
    parameter int ADDR_W = 19
);
    logic                start;
    logic                mode;
    logic [2*CH_W+5:0]   threshold;
    logic                busy;
    logic                done;
    logic [3*CH_W-1:0]   pixel_data;
    logic [ADDR_W-1:0]   pic_addr;
    logic                edge_we;
    logic [ADDR_W-1:0]   edge_addr;
    logic [EDGE_W-1:0]   edge_data;

    modport master (
        input  start, mode, threshold, pixel_data,
        output busy, done, pic_addr, edge_we, edge_addr, edge_data
    );

    modport slave (
        output start, mode, threshold, pixel_data,
        input  busy, done, pic_addr, edge_we, edge_addr, edge_data
    );
endinterface
`default_nettype wire

// File: rtl/sobel_engine_param.sv
`default_nettype none
// ============================================================================
// Module      : sobel_engine_param
// Description : Parametrised Sobel edge pass. Reads RGB pixels from the
//               picture BRAM, converts them to grey, applies a 3x3 Sobel
//               operator to every interior pixel and writes one edge flag per
//               interior pixel to the edge BRAM, in raster order.
// Ports       : clk    system clock
//               rst_n  synchronous active-low reset
//               bus    sobel_engine_param_if.master (control, picture read,
//                      edge write)
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_engine_param #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CH_W   = 4,
    parameter int RD_LAT = 2,
    parameter int MARGIN = 25,
    parameter int EDGE_W = 3,
    parameter int ADDR_W = 19
) (
    input wire logic               clk,
    input wire logic               rst_n,
    sobel_engine_param_if.master   bus
);
    localparam int c_GW = CH_W + 3;          // signed gradient width
    localparam int c_MW = 2 * CH_W + 6;      // magnitude / threshold width
    localparam int c_XW = $clog2(IMG_W + 1);
    localparam int c_YW = $clog2(IMG_H + 1);
    localparam int c_LW = $clog2(RD_LAT + 1);

    localparam logic [c_LW-1:0]   c_LAT_LAST = c_LW'(RD_LAT);
    localparam logic [c_XW-1:0]   c_X_LAST   = c_XW'(IMG_W - 2);
    localparam logic [c_YW-1:0]   c_Y_LAST   = c_YW'(IMG_H - 2);
    localparam logic [c_XW-1:0]   c_X_LO     = c_XW'(MARGIN);
    localparam logic [c_XW-1:0]   c_X_HI     = c_XW'(IMG_W - MARGIN);
    localparam logic [c_YW-1:0]   c_Y_LO     = c_YW'(MARGIN);
    localparam logic [c_YW-1:0]   c_Y_HI     = c_YW'(IMG_H - MARGIN);
    localparam logic [ADDR_W-1:0] c_IMG_W_A  = ADDR_W'(IMG_W);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_PRIME = 3'd1;
    localparam logic [2:0] c_S_CALC  = 3'd2;
    localparam logic [2:0] c_S_MAG   = 3'd3;
    localparam logic [2:0] c_S_WRITE = 3'd4;
    localparam logic [2:0] c_S_SHIFT = 3'd5;
    localparam logic [2:0] c_S_DONE  = 3'd6;

    logic [2:0]                     r_state;
    logic [2:0]                     w_next_state;
    logic [c_XW-1:0]                r_x;
    logic [c_YW-1:0]                r_y;
    logic [1:0]                     r_row;   // window row being read
    logic [1:0]                     r_col;   // column being read while priming
    logic [c_LW-1:0]                r_lat;   // cycles since the read was issued
    logic                           r_mode;
    logic [c_MW-1:0]                r_thr;
    logic [2:0][2:0][CH_W-1:0]      r_win;   // [row][col] grey window
    logic signed [c_GW-1:0]         r_gx;
    logic signed [c_GW-1:0]         r_gy;
    logic [c_MW-1:0]                r_mag;

    // ------------------------------------------------------------------
    // Read address: whole column 0..2 while priming, column x+2 on a shift.
    // The address is held for the full read so any BRAM latency up to
    // RD_LAT sees a stable address.
    // ------------------------------------------------------------------
    logic                  w_rd_cap;
    logic [c_XW-1:0]       w_rd_x;
    logic [c_YW-1:0]       w_rd_y;
    logic [ADDR_W-1:0]     w_rd_addr;

    assign w_rd_cap  = (r_lat == c_LAT_LAST);
    assign w_rd_x    = (r_state == c_S_SHIFT) ? (r_x + c_XW'(2)) : c_XW'(r_col);
    assign w_rd_y    = r_y - c_YW'(1) + c_YW'(r_row);
    assign w_rd_addr = ADDR_W'(w_rd_y) * c_IMG_W_A + ADDR_W'(w_rd_x);

    // ------------------------------------------------------------------
    // Grey conversion; the weights sum to 1 so the result fits CH_W bits.
    // ------------------------------------------------------------------
    logic [CH_W-1:0] w_r, w_g, w_b, w_grey;
    assign w_r    = bus.pixel_data[3*CH_W-1 -: CH_W];
    assign w_g    = bus.pixel_data[2*CH_W-1 -: CH_W];
    assign w_b    = bus.pixel_data[CH_W-1:0];
    assign w_grey = (w_r >> 2) + (w_g >> 1) + (w_g >> 3) + (w_b >> 3);

    // ------------------------------------------------------------------
    // Sobel gradients and magnitude
    // ------------------------------------------------------------------
    function automatic logic signed [c_GW-1:0] f_ext(input logic [CH_W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    logic signed [c_GW-1:0] w_gx, w_gy;
    logic [c_GW-1:0]        w_ax, w_ay;
    logic [c_MW-1:0]        w_axe, w_aye, w_mag;

    always_comb begin
        w_gx = f_ext(r_win[0][0]) - f_ext(r_win[0][2])
             + (f_ext(r_win[1][0]) <<< 1) - (f_ext(r_win[1][2]) <<< 1)
             + f_ext(r_win[2][0]) - f_ext(r_win[2][2]);
        w_gy = f_ext(r_win[0][0]) + (f_ext(r_win[0][1]) <<< 1) + f_ext(r_win[0][2])
             - f_ext(r_win[2][0]) - (f_ext(r_win[2][1]) <<< 1) - f_ext(r_win[2][2]);
    end

    // |G| <= 4*(2^CH_W-1), so negating never overflows c_GW bits
    assign w_ax  = r_gx[c_GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
    assign w_ay  = r_gy[c_GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
    assign w_axe = c_MW'(w_ax);
    assign w_aye = c_MW'(w_ay);
    assign w_mag = r_mode ? (w_axe + w_aye) : (w_axe * w_axe + w_aye * w_aye);

    logic w_in_margin, w_edge;
    assign w_in_margin = (r_x < c_X_LO) || (r_x >= c_X_HI) ||
                         (r_y < c_Y_LO) || (r_y >= c_Y_HI);
    assign w_edge      = (r_mag > r_thr) && !w_in_margin;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    logic                w_busy, w_done, w_edge_we;
    logic [ADDR_W-1:0]   w_pic_addr, w_edge_addr;
    logic [EDGE_W-1:0]   w_edge_data;

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_edge_we    = 1'b0;
        w_pic_addr   = '0;
        w_edge_addr  = '0;
        w_edge_data  = '0;
        case (r_state)
            c_S_IDLE: begin
                if (bus.start) w_next_state = c_S_PRIME;
            end
            c_S_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_next_state = c_S_PRIME;
            end
            c_S_PRIME: begin
                w_busy     = 1'b1;
                w_pic_addr = w_rd_addr;
                if (w_rd_cap && r_row == 2'd2 && r_col == 2'd2) w_next_state = c_S_CALC;
            end
            c_S_SHIFT: begin
                w_busy     = 1'b1;
                w_pic_addr = w_rd_addr;
                if (w_rd_cap && r_row == 2'd2) w_next_state = c_S_CALC;
            end
            c_S_CALC: begin
                w_busy       = 1'b1;
                w_next_state = c_S_MAG;
            end
            c_S_MAG: begin
                w_busy       = 1'b1;
                w_next_state = c_S_WRITE;
            end
            c_S_WRITE: begin
                w_busy      = 1'b1;
                w_edge_we   = 1'b1;
                w_edge_addr = ADDR_W'(r_y) * c_IMG_W_A + ADDR_W'(r_x);
                w_edge_data = w_edge ? EDGE_W'(1'b1) : '0;
                if (r_x < c_X_LAST)      w_next_state = c_S_SHIFT;
                else if (r_y < c_Y_LAST) w_next_state = c_S_PRIME;
                else                     w_next_state = c_S_DONE;
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pic_addr  = w_pic_addr;
    assign bus.edge_we   = w_edge_we;
    assign bus.edge_addr = w_edge_addr;
    assign bus.edge_data = w_edge_data;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_lat  <= '0;
            r_mode <= 1'b0;
            r_thr  <= '0;
            r_win  <= '0;
            r_gx   <= '0;
            r_gy   <= '0;
            r_mag  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (bus.start) begin
                        r_x    <= c_XW'(1);
                        r_y    <= c_YW'(1);
                        r_row  <= '0;
                        r_col  <= '0;
                        r_lat  <= '0;
                        r_mode <= bus.mode;
                        r_thr  <= bus.threshold;
                    end
                end
                c_S_PRIME, c_S_SHIFT: begin
                    if (w_rd_cap) begin
                        r_lat <= '0;
                        // Each captured pixel shifts its own row left once, so
                        // three columns fill the window when priming and one
                        // column slides it along on a shift.
                        for (int i = 0; i < 3; i++) begin
                            if (r_row == 2'(i)) begin
                                r_win[i][0] <= r_win[i][1];
                                r_win[i][1] <= r_win[i][2];
                                r_win[i][2] <= w_grey;
                            end
                        end
                        if (r_row == 2'd2) begin
                            r_row <= '0;
                            if (r_state == c_S_PRIME) begin
                                r_col <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
                            end else begin
                                r_x <= r_x + c_XW'(1);
                            end
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end else begin
                        r_lat <= r_lat + c_LW'(1);
                    end
                end
                c_S_CALC: begin
                    r_gx <= w_gx;
                    r_gy <= w_gy;
                end
                c_S_MAG: begin
                    r_mag <= w_mag;
                end
                c_S_WRITE: begin
                    if (!(r_x < c_X_LAST) && (r_y < c_Y_LAST)) begin
                        r_y <= r_y + c_YW'(1);
                        r_x <= c_XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
